// File: rtl/lc9_pkg.sv
// Shared definitions for the LogicCore9 sequencer and control decoder.
// State encoding, sequence landmarks and optional cycle-counter width.
package lc9_pkg;

  localparam int STATE_W = 4;

  localparam logic [STATE_W-1:0] S_IDLE  = 4'd0;
  localparam logic [STATE_W-1:0] S_LOAD2 = 4'd7;
  localparam logic [STATE_W-1:0] S_DONE  = 4'd13;

  // First encoding that is never reached by a legal sequence.
  localparam int ILLEGAL_MIN = 14;

  localparam int CNT_W = 8;

  function automatic logic is_load_state(input logic [STATE_W-1:0] s);
    return (s == S_IDLE) || (s == S_LOAD2);
  endfunction

endpackage

// File: rtl/lc9_sequencer.sv
// State-register / sequencer feeding the LogicCore9 control decoder.
// Optional cycle counter output cyc_cnt is enabled by defining LC9_CYCLE_CNT_EN.
module lc9_sequencer
  import lc9_pkg::*;
#(
  parameter int SW          = STATE_W,
  parameter int LOAD2_STATE = int'(S_LOAD2),
  parameter int LAST_STATE  = int'(S_DONE)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          stall,
  input  logic          abort,
  input  logic          ack,
  output logic [SW-1:0] Q,
  output logic          busy,
  output logic          done_pulse,
`ifdef LC9_CYCLE_CNT_EN
  output logic [CNT_W-1:0] cyc_cnt,
`endif
  output logic          err
);

  localparam logic [SW-1:0] IDLE_Q  = '0;
  localparam logic [SW-1:0] LOAD2_Q = SW'(LOAD2_STATE);
  localparam logic [SW-1:0] LAST_Q  = SW'(LAST_STATE);
  localparam logic [SW-1:0] ILL_Q   = SW'(ILLEGAL_MIN);

  logic [SW-1:0] q_reg, q_next;
  logic          err_reg, err_next;
  logic          done_reg, done_next;
  logic          accept;

  assign Q          = q_reg;
  assign busy       = (q_reg != IDLE_Q);
  assign in_ready   = (q_reg == IDLE_Q) || (q_reg == LOAD2_Q);
  assign done_pulse = done_reg;
  assign err        = err_reg;

  // Priority: abort, illegal recovery, stall, then the normal sequence.
  always_comb begin
    q_next   = q_reg;
    err_next = err_reg;
    accept   = 1'b0;
    if (abort && (q_reg != IDLE_Q)) begin
      q_next = IDLE_Q;
    end else if (q_reg >= ILL_Q) begin
      q_next   = IDLE_Q;
      err_next = 1'b1;
    end else if (!stall) begin
      if (q_reg == IDLE_Q) begin
        if (start && in_valid) begin
          q_next   = q_reg + 1'b1;
          accept   = 1'b1;
          err_next = 1'b0;
        end
      end else if (q_reg == LOAD2_Q) begin
        if (in_valid) begin
          q_next = q_reg + 1'b1;
        end
      end else if (q_reg == LAST_Q) begin
        if (ack) begin
          q_next = IDLE_Q;
        end
      end else begin
        q_next = q_reg + 1'b1;
      end
    end
  end

  // Pulse only on the edge that enters DONE; abort never targets DONE.
  assign done_next = (q_next == LAST_Q) && (q_reg != LAST_Q);

`ifdef LC9_CYCLE_CNT_EN
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  assign cyc_cnt = cnt_reg;

  always_comb begin
    cnt_next = cnt_reg;
    if (accept) begin
      cnt_next = '0;
    end else if (busy && (q_reg != LAST_Q) && (cnt_reg != {CNT_W{1'b1}})) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg    <= IDLE_Q;
      err_reg  <= 1'b0;
      done_reg <= 1'b0;
`ifdef LC9_CYCLE_CNT_EN
      cnt_reg  <= '0;
`endif
    end else begin
      q_reg    <= q_next;
      err_reg  <= err_next;
      done_reg <= done_next;
`ifdef LC9_CYCLE_CNT_EN
      cnt_reg  <= cnt_next;
`endif
    end
  end

endmodule

// File: tb/tb_lc9_sequencer.sv
// Directed plus randomized bench for lc9_sequencer against an arithmetic reference model.
`timescale 1ns/1ps
module tb_lc9_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, in_valid, stall, abort, ack;
  logic       in_ready, busy, done_pulse, err;
  logic [3:0] Q;
`ifdef LC9_CYCLE_CNT_EN
  logic [7:0] cyc_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state, plain integers.
  int  mq    = 0;
  bit  merr  = 0;
  bit  mdone = 0;
  int  mcnt  = 0;

  always #5 clk = ~clk;

  lc9_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .stall      (stall),
    .abort      (abort),
    .ack        (ack),
    .Q          (Q),
    .busy       (busy),
    .done_pulse (done_pulse),
`ifdef LC9_CYCLE_CNT_EN
    .cyc_cnt    (cyc_cnt),
`endif
    .err        (err)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    $display("[%0t] %s Q=%0d busy=%0d in_ready=%0d done_pulse=%0d err=%0d",
             $time, tag, Q, busy, in_ready, done_pulse, err);
    chk({tag, ".Q"}, int'(Q), mq);
    chk({tag, ".busy"}, int'(busy), int'(mq != 0));
    chk({tag, ".in_ready"}, int'(in_ready), int'(mq == 0 || mq == 7));
    chk({tag, ".done_pulse"}, int'(done_pulse), int'(mdone));
    chk({tag, ".err"}, int'(err), int'(merr));
`ifdef LC9_CYCLE_CNT_EN
    chk({tag, ".cyc_cnt"}, int'(cyc_cnt), mcnt);
`endif
  endtask

  task automatic model_reset();
    mq = 0; merr = 0; mdone = 0; mcnt = 0;
  endtask

  // One clock of the sequence rules, written from the behavioural description.
  task automatic model_clock(input bit st, input bit iv, input bit sl, input bit ab, input bit ak);
    int nq;
    bit acc;
    nq  = mq;
    acc = (mq == 0) && st && iv && !sl;
    if (ab && mq != 0)      nq = 0;
    else if (mq >= 14)      begin nq = 0; merr = 1; end
    else if (sl)            nq = mq;
    else if (mq == 0)       nq = (st && iv) ? 1 : 0;
    else if (mq == 7)       nq = iv ? 8 : 7;
    else if (mq == 13)      nq = ak ? 0 : 13;
    else                    nq = mq + 1;
    if (acc) merr = 0;
    if (acc)                                    mcnt = 0;
    else if (mq != 0 && mq != 13 && mcnt < 255) mcnt = mcnt + 1;
    mdone = (nq == 13) && (mq != 13);
    mq    = nq;
  endtask

  // Called at posedge+1; drives inputs, checks combinational outputs, advances one edge.
  task automatic step(input string tag, input bit st, input bit iv, input bit sl,
                      input bit ab, input bit ak);
    start = st; in_valid = iv; stall = sl; abort = ab; ack = ak;
    #2;
    chk({tag, ".pre_in_ready"}, int'(in_ready), int'(mq == 0 || mq == 7));
    model_clock(st, iv, sl, ab, ak);
    @(posedge clk); #1;
    chk_all(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 0; in_valid = 0; stall = 0; abort = 0; ack = 0;
    model_reset();
    #3;
    chk_all("reset");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk_all("post_reset");

    // Nominal operation.
    step("nom_accept", 1, 1, 0, 0, 0);
    for (int i = 0; i < 12; i++) step("nom_run", 0, 1, 0, 0, 0);
    chk("nom_q13", int'(Q), 13);
    chk("nom_pulse", int'(done_pulse), 1);
    step("nom_hold", 0, 1, 0, 0, 0);
    chk("nom_pulse_once", int'(done_pulse), 0);
    step("nom_hold", 1, 1, 0, 0, 0);
    step("nom_ack", 0, 0, 0, 0, 1);
    chk("nom_idle", int'(Q), 0);

    // Load wait at state 7, then stall at 10.
    step("lw_accept", 1, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) step("lw_run", 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("lw_wait", 0, 0, 0, 0, 0);
    chk("lw_hold7", int'(Q), 7);
    step("lw_load", 0, 1, 0, 0, 0);
    chk("lw_q8", int'(Q), 8);
    step("lw_run", 0, 1, 0, 0, 0);
    step("lw_run", 0, 1, 0, 0, 0);
    step("stall", 0, 1, 1, 0, 0);
    step("stall", 0, 1, 1, 0, 0);
    chk("stall_hold10", int'(Q), 10);
    for (int i = 0; i < 3; i++) step("st_run", 0, 1, 0, 0, 0);
    for (int i = 0; i < 2; i++) step("st_done_hold", 0, 1, 0, 0, 0);
    step("abort_ack", 0, 0, 0, 1, 1);

    // Abort wins over stall.
    step("ab_accept", 1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("ab_run", 0, 1, 0, 0, 0);
    step("ab_stall", 0, 1, 1, 1, 0);
    chk("abort_idle", int'(Q), 0);

    // Illegal state recovery, then cleared by an accepted start.
    force dut.q_reg = 4'd14;
    #1 release dut.q_reg;
    mq = 14;
    chk("ill_forced", int'(Q), 14);
    step("ill_recover", 0, 0, 1, 0, 0);
    chk("ill_err", int'(err), 1);
    step("ill_idle", 0, 1, 0, 0, 0);
    step("ill_clear", 1, 1, 0, 0, 0);
    chk("ill_err_clr", int'(err), 0);

    // Asynchronous reset mid-operation at Q=5.
    for (int i = 0; i < 4; i++) step("rst_run", 0, 1, 0, 0, 0);
    chk("rst_q5", int'(Q), 5);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk_all("async_reset");
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk_all("after_reset");

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      step("rand",
           bit'($urandom_range(1, 0)),
           bit'($urandom_range(9, 0) < 7),
           bit'($urandom_range(9, 0) == 0),
           bit'($urandom_range(29, 0) == 0),
           bit'($urandom_range(3, 0) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
